// File: rtl/itch_payload_assembler.sv
// Packs a framed ITCH byte stream into a left-aligned 512-bit payload word, checking
// each message length against a per-type table and dropping/counting bad messages.
module itch_payload_assembler #(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic                   in_eof,
    input  logic [7:0]             in_data,
    output logic [8*MAX_BYTES-1:0] payload,
    output logic                   payload_valid,
    output logic                   length_error,
    output logic                   unknown_type,
    output logic [CNT_W-1:0]       msg_count,
    output logic [CNT_W-1:0]       err_count
);

    localparam int LEN_W = $clog2(MAX_BYTES + 1);
    localparam int IDX_W = $clog2(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DROP
    } state_t;

    state_t                      r_state;
    logic [LEN_W-1:0]            r_count;
    logic [LEN_W-1:0]            r_exp_len;
    logic [MAX_BYTES-1:0][7:0]   r_payload;
    logic                        r_payload_valid;
    logic                        r_length_error;
    logic                        r_unknown_type;
    logic [CNT_W-1:0]            r_msg_count;
    logic [CNT_W-1:0]            r_err_count;

    state_t                      w_state_nxt;
    logic [LEN_W-1:0]            w_count_nxt;
    logic [LEN_W-1:0]            w_exp_nxt;
    logic [LEN_W-1:0]            w_type_len;
    logic [LEN_W-1:0]            w_count_inc;
    logic                        w_pv_nxt;
    logic                        w_le_nxt;
    logic                        w_ut_nxt;
    logic                        w_clear;
    logic                        w_wr;
    logic [IDX_W-1:0]            w_wr_idx;
    logic [1:0]                  w_err_inc;
    logic [CNT_W:0]              w_err_sum;

    // Zero marks a type byte that has no entry in the table.
    function automatic logic [LEN_W-1:0] type_len(input logic [7:0] t);
        case (t)
            8'h41:        return LEN_W'(26);
            8'h44:        return LEN_W'(9);
            8'h58, 8'h45: return LEN_W'(13);
            default:      return '0;
        endcase
    endfunction

    assign w_type_len  = type_len(in_data);
    assign w_count_inc = r_count + LEN_W'(1);
    assign w_wr_idx    = IDX_W'(MAX_BYTES - 1) - r_count[IDX_W-1:0];
    assign w_err_inc   = {1'b0, w_le_nxt} + {1'b0, w_ut_nxt};
    assign w_err_sum   = {1'b0, r_err_count} + (CNT_W+1)'(w_err_inc);

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_exp_nxt   = r_exp_len;
        w_pv_nxt    = 1'b0;
        w_le_nxt    = 1'b0;
        w_ut_nxt    = 1'b0;
        w_clear     = 1'b0;
        w_wr        = 1'b0;
        if (in_valid) begin
            if (in_sof) begin
                // A sof inside a live message truncates it, then starts the new one.
                if (r_state == S_COLLECT) w_le_nxt = 1'b1;
                w_clear     = 1'b1;
                w_count_nxt = LEN_W'(1);
                w_exp_nxt   = w_type_len;
                if (w_type_len == '0) begin
                    w_ut_nxt    = 1'b1;
                    w_state_nxt = in_eof ? S_IDLE : S_DROP;
                end else if (in_eof) begin
                    w_le_nxt    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end else begin
                case (r_state)
                    S_COLLECT: begin
                        if (w_count_inc > r_exp_len) begin
                            w_le_nxt    = 1'b1;
                            w_state_nxt = in_eof ? S_IDLE : S_DROP;
                        end else begin
                            w_wr        = 1'b1;
                            w_count_nxt = w_count_inc;
                            if (in_eof) begin
                                w_pv_nxt    = (w_count_inc == r_exp_len);
                                w_le_nxt    = (w_count_inc != r_exp_len);
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end
                    S_DROP: begin
                        if (in_eof) w_state_nxt = S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_count         <= '0;
            r_exp_len       <= '0;
            r_payload_valid <= 1'b0;
            r_length_error  <= 1'b0;
            r_unknown_type  <= 1'b0;
            r_msg_count     <= '0;
            r_err_count     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_count         <= w_count_nxt;
            r_exp_len       <= w_exp_nxt;
            r_payload_valid <= w_pv_nxt;
            r_length_error  <= w_le_nxt;
            r_unknown_type  <= w_ut_nxt;
            if (w_pv_nxt && (r_msg_count != '1)) r_msg_count <= r_msg_count + CNT_W'(1);
            r_err_count     <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
        end
    end

    // NOTE: the payload is a register bank, not a RAM, so it is reset and reads zero
    // after reset like every other output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_payload <= '0;
        end else if (w_clear) begin
            r_payload                <= '0;
            r_payload[MAX_BYTES-1]   <= in_data;
        end else if (w_wr) begin
            r_payload[w_wr_idx]      <= in_data;
        end
    end

    assign payload       = r_payload;
    assign payload_valid = r_payload_valid;
    assign length_error  = r_length_error;
    assign unknown_type  = r_unknown_type;
    assign msg_count     = r_msg_count;
    assign err_count     = r_err_count;

endmodule

// File: tb/tb_itch_payload_assembler.sv
// Directed bench for itch_payload_assembler: good, gapped, short, long, unknown,
// truncated, single-byte and reset-mid-message cases.
module tb_itch_payload_assembler;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic         in_eof = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic [511:0] payload;
    logic         payload_valid;
    logic         length_error;
    logic         unknown_type;
    logic [15:0]  msg_count;
    logic [15:0]  err_count;

    int total = 0;
    int bad   = 0;
    int n_pv  = 0;
    int n_le  = 0;
    int n_ut  = 0;
    int s_pv, s_le, s_ut;

    itch_payload_assembler #(.MAX_BYTES(64), .CNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_eof        (in_eof),
        .in_data       (in_data),
        .payload       (payload),
        .payload_valid (payload_valid),
        .length_error  (length_error),
        .unknown_type  (unknown_type),
        .msg_count     (msg_count),
        .err_count     (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (payload_valid) n_pv++;
        if (length_error)  n_le++;
        if (unknown_type)  n_ut++;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] body_byte(input int k);
        return 8'(k * 7 + 3);
    endfunction

    function automatic logic [511:0] exp_payload(input logic [7:0] t, input int n);
        logic [511:0] p = '0;
        p[511:504] = t;
        for (int k = 1; k < n; k++) p[511 - 8*k -: 8] = body_byte(k);
        return p;
    endfunction

    // Inputs change on the falling edge; returns one falling edge after the capture.
    task automatic send_byte(input logic sof, input logic eof, input logic [7:0] d, input int gap);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_eof   = eof;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] t, input int n, input bit gaps);
        for (int k = 0; k < n; k++)
            send_byte(k == 0, k == n - 1, (k == 0) ? t : body_byte(k),
                      gaps ? int'($urandom_range(0, 2)) : 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_pv = n_pv;
        s_le = n_le;
        s_ut = n_ut;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_payload", payload, '0);
        check("rst_pv", payload_valid, 0);
        check("rst_le", length_error, 0);
        check("rst_ut", unknown_type, 0);
        check("rst_msg", msg_count, 0);
        check("rst_err", err_count, 0);
        rst = 1'b0;
        idle(2);

        // 'A' 26 bytes, back to back
        send_msg(8'h41, 26, 0);
        check("a_pv", payload_valid, 1);
        check("a_payload", payload, exp_payload(8'h41, 26));
        check("a_type_byte", payload[511:504], 8'h41);
        check("a_tail_zero", payload[303:0], '0);
        check("a_last_byte", payload[311:304], body_byte(25));
        check("a_msg", msg_count, 1);
        idle(3);
        check("a_pv_one_cycle", payload_valid, 0);
        check("a_payload_held", payload, exp_payload(8'h41, 26));

        // Same 'A' with random gaps
        snap();
        send_msg(8'h41, 26, 1);
        check("ag_pv", payload_valid, 1);
        check("ag_payload", payload, exp_payload(8'h41, 26));
        check("ag_msg", msg_count, 2);
        idle(2);
        check("ag_one_pulse", n_pv - s_pv, 1);

        // Stray byte in IDLE is ignored
        snap();
        send_byte(0, 1, 8'h44, 0);
        idle(2);
        check("stray_pulses", n_pv + n_le + n_ut - s_pv - s_le - s_ut, 0);
        check("stray_payload", payload, exp_payload(8'h41, 26));

        // 'A' ending at byte 20 is short
        snap();
        send_msg(8'h41, 20, 0);
        check("short_le", length_error, 1);
        check("short_pv", payload_valid, 0);
        check("short_err", err_count, 1);
        idle(2);
        check("short_le_once", n_le - s_le, 1);
        check("short_no_pv", n_pv - s_pv, 0);
        check("short_msg", msg_count, 2);

        // 'A' of 30 bytes: error on byte 27, remaining bytes dropped
        snap();
        for (int k = 0; k < 30; k++) begin
            send_byte(k == 0, k == 29, (k == 0) ? 8'h41 : body_byte(k), 0);
            if (k == 26) check("long_le_at27", length_error, 1);
        end
        idle(2);
        check("long_le_once", n_le - s_le, 1);
        check("long_no_pv", n_pv - s_pv, 0);
        check("long_err", err_count, 2);
        send_msg(8'h44, 9, 0);
        check("d_pv", payload_valid, 1);
        check("d_payload", payload, exp_payload(8'h44, 9));
        check("d_msg", msg_count, 3);
        idle(2);

        // Unknown type 'Z' then a good 'X'
        snap();
        send_byte(1, 0, 8'h5A, 0);
        check("z_ut", unknown_type, 1);
        for (int k = 1; k < 13; k++) send_byte(0, k == 12, body_byte(k), 0);
        idle(2);
        check("z_ut_once", n_ut - s_ut, 1);
        check("z_no_le", n_le - s_le, 0);
        check("z_err", err_count, 3);
        send_msg(8'h58, 13, 0);
        check("x_pv", payload_valid, 1);
        check("x_payload", payload, exp_payload(8'h58, 13));
        check("x_msg", msg_count, 4);
        idle(2);

        // sof at byte 10 of an 'A' truncates it; the new 'D' is intact
        snap();
        for (int k = 0; k < 10; k++) send_byte(k == 0, 0, (k == 0) ? 8'h41 : body_byte(k), 0);
        send_byte(1, 0, 8'h44, 0);
        check("trunc_le", length_error, 1);
        check("trunc_err", err_count, 4);
        for (int k = 1; k < 9; k++) send_byte(0, k == 8, body_byte(k), 0);
        check("trunc_d_pv", payload_valid, 1);
        check("trunc_d_payload", payload, exp_payload(8'h44, 9));
        check("trunc_d_msg", msg_count, 5);
        idle(2);
        check("trunc_le_once", n_le - s_le, 1);

        // Truncating sof with an unknown type: both pulses, err += 2
        for (int k = 0; k < 5; k++) send_byte(k == 0, 0, (k == 0) ? 8'h45 : body_byte(k), 0);
        send_byte(1, 0, 8'h5A, 0);
        check("trunc_unk_le", length_error, 1);
        check("trunc_unk_ut", unknown_type, 1);
        check("trunc_unk_err", err_count, 6);
        send_byte(0, 1, 8'h00, 0);
        idle(2);

        // One-byte message: sof and eof together
        send_byte(1, 1, 8'h44, 0);
        check("one_byte_le", length_error, 1);
        check("one_byte_pv", payload_valid, 0);
        check("one_byte_err", err_count, 7);
        idle(2);

        // Reset at byte 5 of an 'A'
        for (int k = 0; k < 5; k++) send_byte(k == 0, 0, (k == 0) ? 8'h41 : body_byte(k), 0);
        rst = 1'b1;
        #1;
        check("mrst_payload", payload, '0);
        check("mrst_msg", msg_count, 0);
        check("mrst_err", err_count, 0);
        check("mrst_pulses", {payload_valid, length_error, unknown_type}, 3'b000);
        idle(2);
        rst = 1'b0;
        idle(1);
        snap();
        for (int k = 5; k < 26; k++) send_byte(0, k == 25, body_byte(k), 0);
        idle(2);
        check("mrst_tail_ignored", n_pv + n_le + n_ut - s_pv - s_le - s_ut, 0);
        send_msg(8'h44, 9, 0);
        check("mrst_d_pv", payload_valid, 1);
        check("mrst_d_payload", payload, exp_payload(8'h44, 9));
        check("mrst_d_msg", msg_count, 1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
